// File: rtl/seq_div_if.sv
// Handshake and result bundle for seq_div.
//   start/dividend/divisor : request side, driven by the master
//   busy/done/q/r/div_by_zero : result side, driven by the divider (slave)
interface seq_div_if #(
   parameter int unsigned N = 8
);
   logic         start;
   logic [N-1:0] dividend;
   logic [N-1:0] divisor;
   logic         busy;
   logic         done;
   logic [N-1:0] q;
   logic [N-1:0] r;
   logic         div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, q, r, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, q, r, div_by_zero
   );
endinterface

// File: rtl/seq_div.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : seq_div_if.slave -- start/dividend/divisor in;
//           busy/done/q/r/div_by_zero out (all registered)
module seq_div #(
   parameter int unsigned N = 8
) (
   input logic      clk,
   input logic      rst_n,
   seq_div_if.slave bus
);

   localparam int unsigned CW = $clog2(N);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q,   cnt_d;
   logic [N-1:0]  rem_q,   rem_d;
   logic [N-1:0]  quo_q,   quo_d;
   logic [N-1:0]  dvs_q,   dvs_d;
   logic [N-1:0]  q_q,     q_d;
   logic [N-1:0]  r_q,     r_d;
   logic          dz_q,    dz_d;
   logic          busy_q,  busy_d;
   logic          done_q,  done_d;

   // One restoring step. The stored remainder is always < divisor, so its
   // top bit (bit N of the architectural N+1-bit remainder) is always zero
   // and only N bits are kept.
   logic [N:0]   iter_t;
   logic [N:0]   iter_diff;
   logic [N-1:0] iter_rem;
   logic [N-1:0] iter_quo;

   always_comb begin
      iter_t    = {rem_q, quo_q[N-1]};
      iter_diff = iter_t - {1'b0, dvs_q};
      if (!iter_diff[N]) begin
         iter_rem = iter_diff[N-1:0];
         iter_quo = {quo_q[N-2:0], 1'b1};
      end else begin
         iter_rem = iter_t[N-1:0];
         iter_quo = {quo_q[N-2:0], 1'b0};
      end
   end

   // Next-state and register updates.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      q_d     = q_q;
      r_d     = r_q;
      dz_d    = dz_q;

      if (bus.start && (state_q != S_RUN)) begin
         // Accepted from IDLE or DONE (back-to-back).
         if (bus.divisor == '0) begin
            state_d = S_DONE;
            q_d     = '1;
            r_d     = bus.dividend;
            dz_d    = 1'b1;
         end else begin
            state_d = S_RUN;
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = bus.dividend;
            dvs_d   = bus.divisor;
         end
      end else begin
         case (state_q)
            S_RUN: begin
               rem_d = iter_rem;
               quo_d = iter_quo;
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(N - 1)) begin
                  state_d = S_DONE;
                  cnt_d   = '0;
                  q_d     = iter_quo;
                  r_d     = iter_rem;
                  dz_d    = 1'b0;
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end

      busy_d = (state_d == S_RUN);
      done_d = (state_d == S_DONE);
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         dz_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         q_q     <= q_d;
         r_q     <= r_d;
         dz_q    <= dz_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.q           = q_q;
   assign bus.r           = r_q;
   assign bus.div_by_zero = dz_q;

endmodule
